// File: rtl/snoop_bridge.sv
// ----------------------------------------------------------------------------
// snoop_bridge
//
// Purpose:
//   Takes the write strobes snooped from the SPI front-end and retires them
//   into the CPU memories through a small in-order write queue. Program writes
//   go to the dedicated program-memory write port. Data writes share the data
//   port with the CPU, and the CPU always wins. When the bridge has nothing to
//   write, it keeps snoopq equal to data memory at snoopa by refreshing it
//   with single-cycle reads.
//
// Ports:
//   clk, reset_n              clock and synchronous active-low reset
//   snoopa/snoopd             snoop address (held) and write data
//   snoopp/snoopm             one-cycle program-write / data-write strobes
//   snoopq                    registered data-memory contents at snoopa
//   prog_we/addr/wdata        program memory write port
//   mem_cpu_active            CPU owns the data port this cycle
//   mem_en/we/addr/wdata      bridge side of the shared data port
//   mem_rdata                 synchronous read data, valid one cycle after issue
//   busy                      queue non-empty, read in flight, or snoopq stale
//   overflow                  sticky flag: a strobe was dropped
// ----------------------------------------------------------------------------
module snoop_bridge #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] snoopa,
    input  logic [DW-1:0] snoopd,
    input  logic          snoopp,
    input  logic          snoopm,
    output logic [DW-1:0] snoopq,
    output logic          prog_we,
    output logic [AW-1:0] prog_addr,
    output logic [DW-1:0] prog_wdata,
    input  logic          mem_cpu_active,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t state;

    // Queue storage; sel=1 marks a program write, sel=0 a data write.
    logic          fifo_sel  [FIFO_DEPTH];
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    logic          stale;
    logic [AW-1:0] last_a;

    logic          empty;
    logic          full;
    logic          head_sel;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          strobe;
    logic          push;
    logic          drop;
    logic          do_prog;
    logic          do_dwr;
    logic          do_rd;
    logic          pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign head_sel  = fifo_sel[rd_ptr[PW-1:0]];
    assign head_addr = fifo_addr[rd_ptr[PW-1:0]];
    assign head_data = fifo_data[rd_ptr[PW-1:0]];

    // A double strobe keeps only the program write but still counts as a drop.
    assign strobe    = snoopp | snoopm;
    assign push      = reset_n && strobe && !full;
    assign drop      = reset_n && ((snoopp && snoopm) || (strobe && full));

    // Retire decisions. The head is never bypassed, so a stalled data write
    // also holds back any program writes queued behind it. Refresh reads only
    // happen with an empty queue, which gives writes priority over reads.
    assign do_prog   = reset_n && (state == IDLE) && !empty && head_sel;
    assign do_dwr    = reset_n && (state == IDLE) && !empty && !head_sel &&
                       !mem_cpu_active;
    assign do_rd     = reset_n && (state == IDLE) && empty && stale &&
                       !mem_cpu_active;
    assign pop       = do_prog | do_dwr;

    assign prog_we    = do_prog;
    assign prog_addr  = head_addr;
    assign prog_wdata = head_data;

    assign mem_en     = do_dwr | do_rd;
    assign mem_we     = do_dwr;
    assign mem_addr   = do_rd ? snoopa : head_addr;
    assign mem_wdata  = head_data;

    assign busy       = !empty || (state == RD_WAIT) || stale;

    // Write queue: push at the tail on an accepted strobe, pop the head when
    // it retires. A full queue refuses the push even if the head pops in the
    // same cycle; the freed slot becomes usable on the following cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_sel[wr_ptr[PW-1:0]]  <= snoopp;
                fifo_addr[wr_ptr[PW-1:0]] <= snoopa;
                fifo_data[wr_ptr[PW-1:0]] <= snoopd;
                wr_ptr                    <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Read-refresh FSM and snoop status. stale is registered, so an address
    // change is noticed one cycle later. A change during RD_WAIT lets the
    // capture finish and then causes another read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            stale    <= 1'b1;
            last_a   <= '0;
            snoopq   <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (do_rd) begin
                        last_a <= snoopa;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    snoopq <= mem_rdata;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (do_rd) begin
                stale <= 1'b0;
            end else if (do_dwr || (snoopa != last_a)) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snoop_bridge.sv
// ----------------------------------------------------------------------------
// tb_snoop_bridge
//
// Purpose:
//   Self-checking bench for snoop_bridge. It provides a synchronous RAM on
//   the shared data port and records every port transaction into an event
//   log. The reference model is an ordered list of the writes that should
//   retire, plus an image of what data memory should contain.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_snoop_bridge;

    typedef struct packed {
        logic [1:0] kind;   // 0 program write, 1 data write, 2 data read
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] snoopa;
    logic [7:0] snoopd;
    logic       snoopp;
    logic       snoopm;
    logic [7:0] snoopq;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_wdata;
    logic       mem_cpu_active;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       overflow;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    ev_t        ev_log  [$];
    int         viol = 0;
    int         errors = 0;
    int         checks = 0;

    snoop_bridge #(.AW(8), .DW(8), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .snoopa         (snoopa),
        .snoopd         (snoopd),
        .snoopp         (snoopp),
        .snoopm         (snoopm),
        .snoopq         (snoopq),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_wdata     (prog_wdata),
        .mem_cpu_active (mem_cpu_active),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Synchronous RAM behind the shared data port.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) begin
                ram[mem_addr] = mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Port monitor. Inputs change just after posedge, so values at negedge are
    // exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (prog_we === 1'b1) begin
            ev_log.push_back({2'd0, prog_addr, prog_wdata});
        end
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            ev_log.push_back({2'd1, mem_addr, mem_wdata});
        end
        if (mem_en === 1'b1 && mem_we === 1'b0) begin
            ev_log.push_back({2'd2, mem_addr, 8'h00});
        end
        if (mem_en === 1'b1 && mem_cpu_active === 1'b1) begin
            viol++;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Run clock cycles until busy drops, optionally randomizing CPU ownership.
    task automatic wait_idle(input int budget, input bit rand_cpu, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rand_cpu) begin
                mem_cpu_active = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        mem_cpu_active = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bit found;
        reset_n        = 1'b0;
        snoopa         = 8'h00;
        snoopd         = 8'h00;
        snoopp         = 1'b0;
        snoopm         = 1'b0;
        mem_cpu_active = 1'b0;
        ram[0]         = 8'h5A;
        ref_mem[0]     = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({prog_we, mem_en, mem_we} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_enables cycle %0d: got %b expected 000", i, {prog_we, mem_en, mem_we});
            end
            checks++;
            if ({snoopq, overflow} !== 9'h000) begin
                errors++;
                $display("[TB] FAIL reset_state cycle %0d: snoopq=%h overflow=%b expected 00/0", i, snoopq, overflow);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (snoopq === 8'h5A) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reset_refresh: snoopq=%h expected 5a within 3 cycles", snoopq);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_prog_write();
        bit ok;
        int nprog;
        int ndata;
        @(posedge clk);
        #1;
        ev_log.delete();
        snoopa = 8'h10;
        snoopd = 8'hC3;
        snoopp = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_early: prog_we=%b expected 0 in strobe cycle", prog_we);
        end
        @(posedge clk);
        #1;
        snoopp = 1'b0;
        @(negedge clk);
        checks++;
        if ({prog_we, prog_addr, prog_wdata, mem_en} !== {1'b1, 8'h10, 8'hC3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL prog_write: we=%b addr=%h data=%h mem_en=%b expected 1/10/c3/0", prog_we, prog_addr, prog_wdata, mem_en);
        end
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prog_single: prog_we=%b expected 0 after one cycle", prog_we);
        end
        wait_idle(50, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL prog_idle: busy=%b expected 0 within budget", busy);
        end
        nprog = 0;
        ndata = 0;
        foreach (ev_log[i]) begin
            if (ev_log[i].kind == 2'd0) nprog++;
            if (ev_log[i].kind == 2'd1) ndata++;
        end
        checks++;
        if (nprog != 1 || ndata != 0) begin
            errors++;
            $display("[TB] FAIL prog_count: prog=%0d data=%0d expected 1/0", nprog, ndata);
        end
    endtask

    task automatic test_cpu_stall();
        bit ok;
        int en_seen;
        int v0;
        v0 = viol;
        @(posedge clk);
        #1;
        ev_log.delete();
        mem_cpu_active = 1'b1;
        snoopa         = 8'h20;
        snoopd         = 8'h7E;
        snoopm         = 1'b1;
        ref_mem[8'h20] = 8'h7E;
        @(posedge clk);
        #1;
        snoopm  = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_en !== 1'b0) en_seen++;
            @(posedge clk);
            #1;
        end
        mem_cpu_active = 1'b0;
        checks++;
        if (en_seen != 0) begin
            errors++;
            $display("[TB] FAIL stall_mem_en: mem_en high in %0d cpu cycles, expected 0", en_seen);
        end
        wait_idle(50, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL stall_idle: busy=%b expected 0 within budget", busy);
        end
        checks++;
        if (ev_log.size() != 2) begin
            errors++;
            $display("[TB] FAIL stall_events: %0d port events, expected 2", ev_log.size());
        end else begin
            checks++;
            if (ev_log[0] !== {2'd1, 8'h20, 8'h7E} || ev_log[1] !== {2'd2, 8'h20, 8'h00}) begin
                errors++;
                $display("[TB] FAIL stall_order: events %h %h expected 1207e 22000", ev_log[0], ev_log[1]);
            end
        end
        checks++;
        if (snoopq !== 8'h7E) begin
            errors++;
            $display("[TB] FAIL stall_snoopq: snoopq=%h expected 7e", snoopq);
        end
        checks++;
        if (viol != v0) begin
            errors++;
            $display("[TB] FAIL stall_priority: %0d cycles with mem_en during cpu access, expected 0", viol - v0);
        end
    endtask

    task automatic test_addr_change();
        bit ok;
        ram[8'h33]     = 8'hA5;
        ref_mem[8'h33] = 8'hA5;
        @(posedge clk);
        #1;
        snoopa = 8'h00;
        wait_idle(50, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL addr_settle: busy=%b expected 0 within budget", busy);
        end
        @(posedge clk);
        #1;
        snoopa = 8'h33;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL addr_early_read: mem_en=%b expected 0 in change cycle", mem_en);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h33}) begin
            errors++;
            $display("[TB] FAIL addr_read_issue: en=%b we=%b addr=%h expected 1/0/33", mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (snoopq !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL addr_snoopq: snoopq=%h expected a5", snoopq);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        ev_t exp_q[$];
        ev_t got_q[$];
        @(posedge clk);
        #1;
        ev_log.delete();
        mem_cpu_active = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            snoopa = 8'(8'h40 + i - 1);
            snoopd = 8'(i);
            snoopm = 1'b1;
            if (exp_q.size() < 4) begin
                exp_q.push_back({2'd1, snoopa, snoopd});
            end
            if (i == 5) begin
                @(negedge clk);
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_at_full: overflow=%b expected 0 with exactly 4 queued", overflow);
                end
            end
            @(posedge clk);
            #1;
        end
        snoopm = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: overflow=%b expected 1", overflow);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky_stall: overflow=%b expected 1", overflow);
        end
        mem_cpu_active = 1'b0;
        wait_idle(60, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ovf_idle: busy=%b expected 0 within budget", busy);
        end
        foreach (ev_log[i]) begin
            if (ev_log[i].kind == 2'd1) got_q.push_back(ev_log[i]);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL ovf_count: %0d data writes, expected %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        foreach (exp_q[i]) ref_mem[exp_q[i].addr] = exp_q[i].data;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky_end: overflow=%b expected 1", overflow);
        end
        checks++;
        if (snoopq !== ref_mem[snoopa]) begin
            errors++;
            $display("[TB] FAIL ovf_snoopq: snoopq=%h expected %h", snoopq, ref_mem[snoopa]);
        end
    endtask

    task automatic test_reset_flush();
        bit ok;
        int nwr;
        @(posedge clk);
        #1;
        ev_log.delete();
        mem_cpu_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            snoopa = 8'(8'h50 + i);
            snoopd = 8'(8'hE0 + i);
            snoopm = 1'b1;
            @(posedge clk);
            #1;
        end
        snoopm = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_pre: busy=%b overflow=%b expected 1/1", busy, overflow);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n        = 1'b1;
        mem_cpu_active = 1'b0;
        wait_idle(50, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL flush_idle: busy=%b expected 0 within budget", busy);
        end
        nwr = 0;
        foreach (ev_log[i]) begin
            if (ev_log[i].kind != 2'd2) nwr++;
        end
        checks++;
        if (nwr != 0) begin
            errors++;
            $display("[TB] FAIL flush_writes: %0d writes after reset, expected 0", nwr);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_overflow: overflow=%b expected 0", overflow);
        end
        checks++;
        if (snoopq !== ref_mem[snoopa]) begin
            errors++;
            $display("[TB] FAIL flush_snoopq: snoopq=%h expected %h", snoopq, ref_mem[snoopa]);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int v0;
        bit sel;
        ev_t wr_q[$];
        ev_t got_q[$];
        v0 = viol;
        for (int it = 0; it < 20; it++) begin
            wr_q.delete();
            got_q.delete();
            @(posedge clk);
            #1;
            ev_log.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                sel            = 1'($urandom_range(0, 1));
                snoopa         = 8'($urandom_range(0, 255));
                snoopd         = 8'($urandom);
                snoopp         = sel;
                snoopm         = !sel;
                mem_cpu_active = 1'($urandom_range(0, 1));
                wr_q.push_back({sel ? 2'd0 : 2'd1, snoopa, snoopd});
                @(posedge clk);
                #1;
            end
            snoopp = 1'b0;
            snoopm = 1'b0;
            wait_idle(300, 1'b1, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL rand_idle[%0d]: busy=%b expected 0 within budget", it, busy);
            end
            foreach (ev_log[i]) begin
                if (ev_log[i].kind != 2'd2) got_q.push_back(ev_log[i]);
            end
            checks++;
            if (got_q.size() != wr_q.size()) begin
                errors++;
                $display("[TB] FAIL rand_count[%0d]: %0d writes, expected %0d", it, got_q.size(), wr_q.size());
            end else begin
                foreach (wr_q[i]) begin
                    checks++;
                    if (got_q[i] !== wr_q[i]) begin
                        errors++;
                        $display("[TB] FAIL rand_write[%0d.%0d]: got %h expected %h", it, i, got_q[i], wr_q[i]);
                    end
                end
            end
            foreach (wr_q[i]) begin
                if (wr_q[i].kind == 2'd1) ref_mem[wr_q[i].addr] = wr_q[i].data;
            end
            checks++;
            if (snoopq !== ref_mem[snoopa]) begin
                errors++;
                $display("[TB] FAIL rand_snoopq[%0d]: snoopq=%h expected %h at %h", it, snoopq, ref_mem[snoopa], snoopa);
            end
        end
        checks++;
        if (viol != v0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_protocol: priority violations=%0d overflow=%b expected 0/0", viol - v0, overflow);
        end
    endtask

    task automatic test_both_strobes();
        bit ok;
        int nprog;
        int ndata;
        @(posedge clk);
        #1;
        ev_log.delete();
        snoopa = 8'h60;
        snoopd = 8'h99;
        snoopp = 1'b1;
        snoopm = 1'b1;
        @(posedge clk);
        #1;
        snoopp = 1'b0;
        snoopm = 1'b0;
        @(negedge clk);
        checks++;
        if ({prog_we, prog_addr, prog_wdata, overflow} !== {1'b1, 8'h60, 8'h99, 1'b1}) begin
            errors++;
            $display("[TB] FAIL both_strobes: we=%b addr=%h data=%h ovf=%b expected 1/60/99/1", prog_we, prog_addr, prog_wdata, overflow);
        end
        wait_idle(50, 1'b0, ok);
        nprog = 0;
        ndata = 0;
        foreach (ev_log[i]) begin
            if (ev_log[i].kind == 2'd0) nprog++;
            if (ev_log[i].kind == 2'd1) ndata++;
        end
        checks++;
        if (!ok || nprog != 1 || ndata != 0) begin
            errors++;
            $display("[TB] FAIL both_count: idle=%b prog=%0d data=%0d expected 1/1/0", ok, nprog, ndata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem_rdata = 8'h00;
        test_reset();
        test_prog_write();
        test_cpu_stall();
        test_addr_change();
        test_overflow();
        test_reset_flush();
        test_random();
        test_both_strobes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
